// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and the
// prescaler divide-ratio derivation.
package countdown_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } timerState_e;

  // Number of clock cycles per countdown tick.
  function automatic int calcDiv(input int clkHz, input int tickHz);
    return clkHz / tickHz;
  endfunction

endpackage

// File: rtl/countdown_timer_ctrl_tick_gen.sv
// Prescaler for the countdown timer. Counts 0..DIV-1 while enabled and wraps
// to 0 after the last count. The tick output flags the terminal count
// combinationally so the parent can decide, in the same cycle, whether the
// wrap is honoured (decrement) or suppressed (pause/load/clear).
module tick_gen #(
  parameter int DIV   = 10,
  parameter int DIV_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sclr,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] r_count;

  // Prescaler register: synchronous clear wins over advance; holds when not enabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (sclr) begin
      r_count <= '0;
    end else if (en) begin
      if (r_count == LAST) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + DIV_W'(1);
      end
    end
  end

  assign tick = (r_count == LAST);

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Run/pause/expire countdown timer. Holds a programmable count and
// decrements it once per prescaler wrap while running. Commands are
// prioritised clear > load > pause > start; only the winner acts.
module countdown_timer_ctrl
  import countdown_timer_ctrl_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int CNT_W   = 16,
  parameter int DIV_W   = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  output logic [CNT_W-1:0] remaining,
  output logic             tick,
  output logic             running,
  output logic             paused,
  output logic             done_pulse,
  output logic             expired
);

  localparam int DIV = calcDiv(CLK_HZ, TICK_HZ);

  timerState_e      r_state;
  timerState_e      w_stateNext;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] w_remainingNext;
  logic             r_tick;
  logic             w_tickNext;
  logic             r_done;
  logic             w_doneNext;
  logic             w_termCount;
  logic             w_prescEn;
  logic             w_prescClr;
  logic             w_remNonZero;

  assign w_remNonZero = (r_remaining != '0);

  tick_gen #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_tickGen (
    .clk   (clk),
    .reset (reset),
    .en    (w_prescEn),
    .sclr  (w_prescClr),
    .tick  (w_termCount)
  );

  // Next-state, counter update and prescaler control. A pause that lands on
  // the terminal count freezes the prescaler at DIV-1 so the resumed run
  // ticks one cycle later; otherwise the pause cycle still counts.
  always_comb begin
    w_stateNext     = r_state;
    w_remainingNext = r_remaining;
    w_tickNext      = 1'b0;
    w_doneNext      = 1'b0;
    w_prescEn       = 1'b0;
    w_prescClr      = 1'b0;
    if (clear) begin
      w_stateNext     = ST_IDLE;
      w_remainingNext = '0;
      w_prescClr      = 1'b1;
    end else if (load) begin
      w_stateNext     = ST_IDLE;
      w_remainingNext = load_val;
      w_prescClr      = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_prescClr = 1'b1;
          if (start && !pause && w_remNonZero) begin
            w_stateNext = ST_RUN;
          end
        end
        ST_RUN: begin
          if (pause) begin
            w_stateNext = ST_PAUSE;
            w_prescEn   = !w_termCount;
          end else begin
            w_prescEn = 1'b1;
            if (w_termCount && w_remNonZero) begin
              w_tickNext      = 1'b1;
              w_remainingNext = r_remaining - CNT_W'(1);
              if (r_remaining == CNT_W'(1)) begin
                w_doneNext  = 1'b1;
                w_stateNext = ST_EXPIRED;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (start && !pause && w_remNonZero) begin
            w_stateNext = ST_RUN;
          end
        end
        ST_EXPIRED: begin
          w_prescClr      = 1'b1;
          w_remainingNext = '0;
        end
        default: begin
          w_stateNext = ST_IDLE;
          w_prescClr  = 1'b1;
        end
      endcase
    end
  end

  // State, count and strobe registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_tick      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_remaining <= w_remainingNext;
      r_tick      <= w_tickNext;
      r_done      <= w_doneNext;
    end
  end

  assign remaining  = r_remaining;
  assign tick       = r_tick;
  assign done_pulse = r_done;
  assign running    = (r_state == ST_RUN);
  assign paused     = (r_state == ST_PAUSE);
  assign expired    = (r_state == ST_EXPIRED);

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl with DIV = 10 and an 8-bit count.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_countdown_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] loadVal;
  logic       start;
  logic       pause;
  logic       clear;
  logic [7:0] remaining;
  logic       tick;
  logic       running;
  logic       paused;
  logic       donePulse;
  logic       expired;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  countdown_timer_ctrl #(
    .CLK_HZ  (10),
    .TICK_HZ (1),
    .CNT_W   (8),
    .DIV_W   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_val   (loadVal),
    .start      (start),
    .pause      (pause),
    .clear      (clear),
    .remaining  (remaining),
    .tick       (tick),
    .running    (running),
    .paused     (paused),
    .done_pulse (donePulse),
    .expired    (expired)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] expRem, input logic expTick,
                          input logic expRun, input logic expPause, input logic expDone,
                          input logic expExp);
    checkOutput({tag, ".remaining"}, remaining, expRem);
    checkOutput({tag, ".tick"}, {7'd0, tick}, {7'd0, expTick});
    checkOutput({tag, ".running"}, {7'd0, running}, {7'd0, expRun});
    checkOutput({tag, ".paused"}, {7'd0, paused}, {7'd0, expPause});
    checkOutput({tag, ".done"}, {7'd0, donePulse}, {7'd0, expDone});
    checkOutput({tag, ".expired"}, {7'd0, expired}, {7'd0, expExp});
  endtask

  // Drive one cycle of command pulses, let the rising edge take them, and
  // return on the following falling edge with the pulses dropped.
  task automatic applyStimulus(input logic ld, input logic [7:0] lv, input logic st,
                               input logic ps, input logic cl);
    load    = ld;
    loadVal = lv;
    start   = st;
    pause   = ps;
    clear   = cl;
    @(negedge clk);
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    clear = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    loadVal = 8'd0;
    start   = 1'b0;
    pause   = 1'b0;
    clear   = 1'b0;
    waitCycles(3);
    checkAll("reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Start with nothing loaded is ignored
    $display("[TB] start with remaining=0");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkAll("t3.start", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      checkOutput("t3.tick", {7'd0, tick}, 8'd0);
      checkOutput("t3.running", {7'd0, running}, 8'd0);
    end

    // Full countdown from 3: a tick every 10 cycles, done on the last one
    $display("[TB] countdown from 3");
    applyStimulus(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
    checkAll("t1.load", 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkAll("t1.start", 8'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      checkOutput("t1.remaining", remaining, 8'(3 - k / 10));
      checkOutput("t1.tick", {7'd0, tick}, (k % 10 == 0) ? 8'd1 : 8'd0);
      checkOutput("t1.done", {7'd0, donePulse}, (k == 30) ? 8'd1 : 8'd0);
      checkOutput("t1.expired", {7'd0, expired}, (k == 30) ? 8'd1 : 8'd0);
    end
    @(negedge clk);
    checkAll("t1.after", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkAll("t1.startExpired", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Pause partway through a period, hold, resume completes the period
    $display("[TB] pause and resume");
    applyStimulus(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
    checkAll("t2.load", 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkAll("t2.start", 8'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(3);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    checkAll("t2.pause", 8'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      checkOutput("t2.held", remaining, 8'd5);
    end
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkAll("t2.resume", 8'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checkOutput("t2.tick", {7'd0, tick}, (k == 6) ? 8'd1 : 8'd0);
      checkOutput("t2.remaining", remaining, (k == 6) ? 8'd4 : 8'd5);
    end

    // Command priority: pause beats start, clear beats load
    $display("[TB] command priority");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    checkAll("t4.pauseStart", 8'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd9, 1'b0, 1'b0, 1'b1);
    checkAll("t4.loadClear", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Pause on the terminal count: no decrement, tick one cycle after resume
    $display("[TB] pause on wrap");
    applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    waitCycles(9);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    checkAll("t4.pauseWrap", 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkAll("t4.resumeWrap", 8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkAll("t4.tickAfterResume", 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    checkAll("t4.clear", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a count
    $display("[TB] reset mid-count");
    applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    waitCycles(14);
    checkOutput("t5.preReset", remaining, 8'd1);
    reset = 1'b1;
    #1;
    checkAll("t5.reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(2);
    reset = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      checkOutput("t5.tick", {7'd0, tick}, 8'd0);
      checkOutput("t5.running", {7'd0, running}, 8'd0);
    end
    checkOutput("t5.remaining", remaining, 8'd0);

    // Load on the wrap that would have expired the timer
    $display("[TB] load on final wrap");
    applyStimulus(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    waitCycles(9);
    applyStimulus(1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
    checkAll("t6.loadWrap", 8'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkAll("t6.after", 8'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
